vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// Parametrised raster timing generator for the VGA output path, running in the
// pixel clock domain. Produces hsync/vsync with configurable polarity, a data-enable
// flag, pixel coordinates and line/frame start strobes. Also provides a DELAY-stage
// copy of sync/de, aligned with the output of a multi-cycle pixel pipeline.
// Replaces the separate hsync/vsync counter pair; vcount advances on hcount wrap,
// with no derived line clock.
// PARAMETERS
// H_RES     1024  active pixels per line
// H_FP      48    horizontal front porch, pixels
// H_SYNC    96    horizontal sync width, pixels
// H_BP      208   horizontal back porch, pixels
// V_RES     768   active lines per frame
// V_FP      1     vertical front porch, lines
// V_SYNC    3     vertical sync width, lines
// V_BP      36    vertical back porch, lines
// H_POL     0     hsync active level (0 = active-low)
// V_POL     0     vsync active level (0 = active-low)
// DELAY     2     pipeline stages on hsync_d/vsync_d/de_d, range 0..15
// CW        12    coordinate width; must satisfy 2**CW >= H_TOTAL and V_TOTAL
// PORTS
// vga_clk      in   1   pixel clock; all logic on the rising edge
// reset_n      in   1   asynchronous active-low reset
// ce           in   1   pixel enable; when low, all state holds
// hsync        out  1   horizontal sync, H_POL polarity
// vsync        out  1   vertical sync, V_POL polarity
// de           out  1   high while (x,y) is inside the active area
// x            out  CW  current pixel column, 0..H_TOTAL-1
// y            out  CW  current line, 0..V_TOTAL-1
// line_start   out  1   one-ce pulse when x==0
// frame_start  out  1   one-ce pulse when x==0 && y==0
// hsync_d      out  1   hsync delayed DELAY ce-qualified cycles
// vsync_d      out  1   vsync delayed DELAY ce-qualified cycles
// de_d         out  1   de delayed DELAY ce-qualified cycles
// BEHAVIOUR
// - Totals: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP; V_TOTAL = V_RES+V_FP+V_SYNC+V_BP.
// - Reset values (while reset_n is low): x=0, y=0, de=0, line_start=0, frame_start=0.
//   hsync/hsync_d = !H_POL; vsync/vsync_d = !V_POL; de_d=0; every delay stage = inactive.
// - All outputs are registered. Within one cycle, x/y/hsync/vsync/de/strobes all
//   describe the same position.
// - First ce=1 edge after reset release: outputs describe (0,0), frame_start=1.
// - Each ce=1 edge advances the position:
//   - x increments.
//   - At x==H_TOTAL-1, x wraps to 0 and y increments.
//   - At y==V_TOTAL-1 and x==H_TOTAL-1, both wrap to 0.
//   - No off-by-one: exactly H_TOTAL pixels per line and V_TOTAL lines per frame.
// - de = (x < H_RES) && (y < V_RES).
// - hsync is active for H_RES+H_FP <= x < H_RES+H_FP+H_SYNC.
// - vsync is active for V_RES+V_FP <= y < V_RES+V_FP+V_SYNC, on whole lines
//   (it changes together with the x 0 transition).
// - ce=0: all outputs and delay stages hold their values. Strobes also hold; they
//   mark a position, not a cycle.
// - Delay line: a DELAY-deep shift register of {hsync,vsync,de}, shifted only when ce=1.
//   With DELAY=0, the _d outputs equal the undelayed outputs in the same cycle.
// - reset_n asserted mid-frame: immediate asynchronous return to the reset values.
//   The frame restarts at (0,0) on the first ce=1 edge after release.
// - Width: counters are CW bits and never exceed TOTAL-1; no modular overflow is relied on.
// - No combinational path from any input to any output.
// TESTING
// - Small timing H_RES=8,H_FP=2,H_SYNC=3,H_BP=1,V_RES=4,V_FP=1,V_SYNC=2,V_BP=1, ce=1
//   -> H_TOTAL=14, V_TOTAL=8.
//   -> hsync low exactly at x=10,11,12; de high for x=0..7 on y=0..3.
//   -> 112 cycles between frame_start pulses.
// - Same timing -> vsync low exactly for y=5,6, i.e. 28 cycles, starting at x=0 of y=5.
//   -> line_start pulses 8 per frame.
// - H_POL=1, V_POL=1 -> sync pulses are active-high at the same positions.
//   -> sync outputs idle low after reset.
// - ce toggled 1,0,0,1 repeatedly -> sequence identical to ce=1 with stalls inserted.
//   -> outputs are frozen while ce=0; frame period is 112 ce=1 cycles.
// - DELAY=3 -> de_d/hsync_d/vsync_d equal de/hsync/vsync from 3 ce=1 edges earlier.
//   -> first 3 values after reset are the inactive levels.
// - reset_n pulsed low at x=5,y=2 -> outputs return to reset values with no clock edge.
//   -> after release, the first ce=1 edge gives x=0, y=0, frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Purpose : bundles the pixel-enable input and every raster timing output of
//           vga_timing_gen so that producer and consumer share one port.
// Signals : ce           - pixel enable (driven by the consumer side)
//           hsync, vsync - sync pulses at the configured polarity
//           de           - active-area flag
//           x, y         - current pixel column / line (CW bits)
//           line_start   - marks x==0
//           frame_start  - marks x==0 && y==0
//           hsync_d, vsync_d, de_d - sync/de delayed to match a pixel pipeline
// Modports: master - the timing generator
//           slave  - the pixel pipeline / display consumer
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          ce;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          hsync_d;
    logic          vsync_d;
    logic          de_d;

    modport master (
        input  ce,
        output hsync, vsync, de, x, y, line_start, frame_start,
               hsync_d, vsync_d, de_d
    );

    modport slave (
        output ce,
        input  hsync, vsync, de, x, y, line_start, frame_start,
               hsync_d, vsync_d, de_d
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Purpose : parametrised raster timing generator in the pixel clock domain.
//           One counter pair (x, y) walks the full raster; y advances when x
//           wraps. All outputs are registered and describe the same position.
//           A DELAY-deep shift register provides sync/de copies aligned with a
//           multi-cycle pixel pipeline.
// Ports   : vga_clk - pixel clock, rising edge
//           reset_n - asynchronous active-low reset
//           vga     - vga_timing_gen_if.master (ce in, timing outputs out)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_RES  = 1024,
    parameter int H_FP   = 48,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 208,
    parameter int V_RES  = 768,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 3,
    parameter int V_BP   = 36,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0,
    parameter int DELAY  = 2,
    parameter int CW     = 12
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_RES);
    localparam logic [CW-1:0] V_ACT  = CW'(V_RES);
    localparam logic [CW-1:0] HS_BEG = CW'(H_RES + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_RES + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_RES + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_RES + V_FP + V_SYNC);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] ZERO   = CW'(0);

    // Idle pattern of {hsync, vsync, de}: syncs at their inactive level, de low.
    localparam logic [2:0] SYNC_IDLE = {~H_POL, ~V_POL, 1'b0};

    // started_q is clear after reset: the first ce edge then loads (0,0)
    // instead of advancing, so the first described position carries
    // frame_start while the reset state itself shows no strobe.
    logic          started_q;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    // hs/vs/act are the undelayed hsync/vsync/de registers.
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          act_q, act_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    // Next raster position and the timing flags decoded from it, so that the
    // registered flags always match the registered coordinates.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!started_q) begin
            x_d = ZERO;
            y_d = ZERO;
        end else if (x_q == H_LAST) begin
            x_d = ZERO;
            if (y_q == V_LAST) begin
                y_d = ZERO;
            end else begin
                y_d = y_q + ONE;
            end
        end else begin
            x_d = x_q + ONE;
            y_d = y_q;
        end

        act_d = (x_d < H_ACT) && (y_d < V_ACT);
        hs_d  = ((x_d >= HS_BEG) && (x_d < HS_END)) ? H_POL : ~H_POL;
        vs_d  = ((y_d >= VS_BEG) && (y_d < VS_END)) ? V_POL : ~V_POL;
        ls_d  = (x_d == ZERO);
        fs_d  = (x_d == ZERO) && (y_d == ZERO);
    end

    // Position and timing registers; everything holds while ce is low.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q <= 1'b0;
            x_q       <= ZERO;
            y_q       <= ZERO;
            hs_q      <= ~H_POL;
            vs_q      <= ~V_POL;
            act_q     <= 1'b0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else if (vga.ce) begin
            started_q <= 1'b1;
            x_q       <= x_d;
            y_q       <= y_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            act_q     <= act_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
        end else begin
            started_q <= started_q;
            x_q       <= x_q;
            y_q       <= y_q;
            hs_q      <= hs_q;
            vs_q      <= vs_q;
            act_q     <= act_q;
            ls_q      <= ls_q;
            fs_q      <= fs_q;
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.de          = act_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;

    generate
        if (DELAY == 0) begin : g_nodly
            assign vga.hsync_d = hs_q;
            assign vga.vsync_d = vs_q;
            assign vga.de_d    = act_q;
        end else begin : g_dly
            // Stage 0 takes the registered outputs, so the last stage lags
            // them by exactly DELAY ce-qualified edges.
            logic [2:0] dly_q [0:DELAY-1];

            // Delay line for {hsync, vsync, de}, shifting only on ce.
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DELAY; i++) begin
                        dly_q[i] <= SYNC_IDLE;
                    end
                end else if (vga.ce) begin
                    dly_q[0] <= {hs_q, vs_q, act_q};
                    for (int i = 1; i < DELAY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end else begin
                    for (int i = 0; i < DELAY; i++) begin
                        dly_q[i] <= dly_q[i];
                    end
                end
            end

            assign vga.hsync_d = dly_q[DELAY-1][2];
            assign vga.vsync_d = dly_q[DELAY-1][1];
            assign vga.de_d    = dly_q[DELAY-1][0];
        end
    endgenerate

endmodule
